// File: rtl/bcd_display_scan_if.sv
// bcd_display_scan_if: BCD time inputs, blink select and multiplexed display pins
interface bcd_display_scan_if;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic [1:0] blink_sel;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  modport master(output hour, min, sec, blink_sel, input seg, dp, an);
  modport slave(input hour, min, sec, blink_sel, output seg, dp, an);
endinterface

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: six-digit time-multiplexed seven-segment driver with frame snapshot and blink
module bcd_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50,
  parameter bit LZB          = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  bcd_display_scan_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [SW-1:0] scan_cnt;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    idx;
  logic [23:0]   snap;
  logic          blink_on, load_pend;
  logic          digit_wrap, frame_wrap, blink_wrap, blank;
  logic [1:0]    field;
  logic [7:0]    field_byte;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  always_comb begin
    digit_wrap = scan_cnt == SW'(SCAN_DIV - 1);
    frame_wrap = digit_wrap && idx == 3'd5;
    blink_wrap = frame_wrap && frame_cnt == FW'(BLINK_FRAMES - 1);
    field      = idx[2:1];
    field_byte = field == 2'd2 ? snap[23:16] : field == 2'd1 ? snap[15:8] : snap[7:0];
    nib        = idx[0] ? field_byte[7:4] : field_byte[3:0];
    // blink_sel codes are field index + 1, so 00 never matches a field
    blank      = (LZB && idx == 3'd5 && nib == 4'd0) ||
                 (!blink_on && bus.blink_sel == field + 2'd1);
    case (nib)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b1000000;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      frame_cnt <= '0;
      idx       <= '0;
      snap      <= '0;
      blink_on  <= 1'b1;
      load_pend <= 1'b1;
      bus.an    <= 6'b111111;
      bus.seg   <= '0;
      bus.dp    <= 1'b0;
    end else begin
      scan_cnt  <= digit_wrap ? '0 : scan_cnt + 1'b1;
      idx       <= !digit_wrap ? idx : idx == 3'd5 ? 3'd0 : idx + 3'd1;
      snap      <= (frame_wrap || load_pend) ? {bus.hour, bus.min, bus.sec} : snap;
      load_pend <= 1'b0;
      frame_cnt <= !frame_wrap ? frame_cnt : blink_wrap ? '0 : frame_cnt + 1'b1;
      blink_on  <= blink_wrap ? ~blink_on : blink_on;
      bus.an    <= ~(6'b000001 << idx);
      bus.seg   <= blank ? 7'b0000000 : glyph;
      bus.dp    <= (idx == 3'd2 || idx == 3'd4) && !blank;
    end
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized scoreboard bench against a frame-level display model
module tb_bcd_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 6 * SD;
  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bcd_display_scan_if bif();
  bcd_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif)
  );
  exp_t        exp_q[$];
  logic [23:0] hist[0:4095];
  int          t = 0;
  int          tests = 0;
  int          fails = 0;
  function automatic logic [6:0] digit(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction
  // Model: with t enabled edges since reset, the digit is (t/SD)%6, the frame is t/FR,
  // and the shown value is whatever the inputs were at the last edge of the previous frame.
  task automatic cyc(input logic r, input logic [7:0] h, m, s, input logic [1:0] bs);
    exp_t        e;
    int          idx, f, fld;
    logic [23:0] sn;
    logic [7:0]  by;
    logic [3:0]  nib;
    logic        blank, bon;
    @(negedge clk);
    rst_n = r;
    bif.hour = h;
    bif.min = m;
    bif.sec = s;
    bif.blink_sel = bs;
    if (!r) begin
      e = {6'b111111, 7'b0000000, 1'b0};
      t = 0;
    end else begin
      hist[t] = {h, m, s};
      idx = (t / SD) % 6;
      f = t / FR;
      sn = t == 0 ? 24'h0 : f == 0 ? hist[0] : hist[f * FR - 1];
      bon = ((f / BF) % 2) == 0;
      fld = idx / 2;
      by = sn[fld * 8 +: 8];
      nib = (idx % 2) != 0 ? by[7:4] : by[3:0];
      blank = (idx == 5 && nib == 4'd0) || (!bon && int'(bs) == fld + 1);
      e.an = 6'b111111 ^ (6'b000001 << idx);
      e.seg = blank ? 7'b0000000 : digit(nib);
      e.dp = (idx == 2 || idx == 4) && !blank;
      t++;
    end
    exp_q.push_back(e);
  endtask
  task automatic run(input int n, input logic r, input logic [7:0] h, m, s, input logic [1:0] bs);
    for (int i = 0; i < n; i++) cyc(r, h, m, s, bs);
  endtask
  always begin : monitor
    exp_t e, got;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {bif.an, bif.seg, bif.dp};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL scan @%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 $time, got.an, got.seg, got.dp, e.an, e.seg, e.dp);
      end
    end
  end
  initial begin
    int k;
    bif.hour = 8'h00;
    bif.min = 8'h00;
    bif.sec = 8'h00;
    bif.blink_sel = 2'b00;
    run(3, 1'b0, 8'h12, 8'h34, 8'h56, 2'b00);
    run(FR + 2 * SD, 1'b1, 8'h12, 8'h34, 8'h56, 2'b00);
    run(40, 1'b1, 8'h12, 8'h34, 8'h57, 2'b00);
    run(2, 1'b0, 8'h05, 8'h34, 8'h57, 2'b00);
    run(2 * FR, 1'b1, 8'h05, 8'h34, 8'h57, 2'b00);
    run(1, 1'b0, 8'h12, 8'h34, 8'h56, 2'b10);
    run(8 * FR, 1'b1, 8'h12, 8'h34, 8'h56, 2'b10);
    run(1, 1'b0, 8'h12, 8'h34, 8'hA3, 2'b00);
    run(2 * FR, 1'b1, 8'h12, 8'h34, 8'hA3, 2'b00);
    run(1, 1'b0, 8'h12, 8'h34, 8'h56, 2'b00);
    run(3 * SD + 2, 1'b1, 8'h12, 8'h34, 8'h56, 2'b00);
    run(1, 1'b0, 8'h12, 8'h34, 8'h56, 2'b00);
    run(FR + 4, 1'b1, 8'h12, 8'h34, 8'h56, 2'b00);
    repeat (60) begin
      logic [7:0] h;
      h = 8'($urandom);
      if ($urandom_range(0, 3) == 0) h[7:4] = 4'h0;
      run($urandom_range(1, 30), $urandom_range(0, 39) != 0, h, 8'($urandom), 8'($urandom),
          2'($urandom));
    end
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed six-digit seven-segment display driver for the digital clock. Consumes the packed 8-bit BCD outputs (`{tens, units}`) of the hour, minute and second counters. Snapshots the inputs once per scan frame and drives one digit at a time with segment patterns, decimal-point separators, leading-zero blanking and an adjust-mode blink. Sits between the counter chain and the board's common-cathode display pins.

## Interface
- `SCAN_DIV`, 1000: clock cycles each digit stays lit; legal values ≥ 2.
- `BLINK_FRAMES`, 50: full scan frames per blink half-period; legal values ≥ 1.
- `LZB`, 1: 1 = blank the hour-tens digit when it is 0.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-low; sampled only on the rising edge of `clk`.
- `hour`  in  8  BCD hours, `{tens[7:4], units[3:0]}`.
- `min`  in  8  BCD minutes, same packing.
- `sec`  in  8  BCD seconds, same packing.
- `blink_sel`  in  2  field selected for adjustment: 00 none, 01 sec, 10 min, 11 hour.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-high.
- `dp`  out  1  decimal point, active-high.
- `an`  out  6  digit enables, active-low, one-hot-low.

## Operation
- Digit index `idx` runs 0..5:
  - 0: sec units
  - 1: sec tens
  - 2: min units
  - 3: min tens
  - 4: hour units
  - 5: hour tens
- `scan_cnt` counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1, it wraps to 0 and `idx` advances, with 5 wrapping to 0. A frame is 6×SCAN_DIV cycles.
- Snapshot: a 24-bit register captures `{hour,min,sec}` at two points:
  - on the edge where `idx` wraps 5→0;
  - on the first enabled edge after reset, via a load-pending flag that reset sets and the first enabled edge clears.
  - Input changes mid-frame never reach the display until the next frame.
- Decode of the snapshot nibble:
  - 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110
  - 5→1101101, 6→1111101, 7→0000111, 8→1111111, 9→1101111
  - nibble > 9→1000000 (dash)
- Blanking (`seg`=0000000, `dp`=0, `an` still active) applies in two cases:
  - LZB=1, idx=5 and the hour-tens nibble is 0;
  - the blink phase is off and `idx` belongs to the field named by `blink_sel`.
- Blink: a frame counter counts 0..BLINK_FRAMES-1 and advances on each 5→0 wrap. On its wrap, `blink_on` toggles.
  - Reset sets `blink_on`=1, i.e. visible.
  - `blink_sel`=00 means no digit is ever blink-blanked.
  - `blink_sel` is sampled combinationally each cycle, not snapshotted.
- `dp` is 1 on idx 2 and idx 4 (the separators) unless that digit is blanked.
- `an` = ~(6'b000001 << idx).

## Timing
- All outputs are registered. They reflect `idx`, snapshot and `blink_on` as held before the same clock edge, i.e. one cycle of latency behind the internal state.
- Reset (`rst_n`=0 at an edge) forces:
  - `an`=111111, `seg`=0000000, `dp`=0
  - `idx`=0, `scan_cnt`=0, frame counter 0, `blink_on`=1, snapshot 0, load-pending=1.
  - Reset asserted mid-frame behaves identically, with no partial-digit carry-over.
- First edge with `rst_n`=1 (E1): the snapshot loads from the inputs. Outputs decode the zero snapshot for idx 0: `an`=111110, `seg`=0111111.
- Second edge (E2): outputs show the loaded sec-units digit.
- Each digit is held SCAN_DIV cycles. The `an` change and the `seg` change occur on the same edge, so there is no ghosting cycle.
- Snapshot load, frame-counter advance and `blink_on` toggle occur on the same edge as the `idx` 5→0 wrap.
- Steady state: new inputs appear on `seg` at most 6×SCAN_DIV+1 cycles after they change.

## Test plan
Parameters: SCAN_DIV=4, BLINK_FRAMES=2.

1. Reset, then release with inputs hour=8'h12, min=8'h34, sec=8'h56.
   - During reset: `an`=111111, `seg`=0.
   - After E2, 4 cycles per digit:
     - sec units: `an`=111110, `seg`=1111101, `dp`=0
     - sec tens: `an`=111101, `seg`=1101101, `dp`=0
     - min units: `an`=111011, `seg`=1100110, `dp`=1
     - min tens: `an`=110111, `seg`=1001111, `dp`=0
     - hour units: `an`=101111, `seg`=1011011, `dp`=1
     - hour tens: `an`=011111, `seg`=0000110, `dp`=0
2. Change sec to 8'h57 while idx=2.
   - Remainder of the frame still shows 5/6.
   - Next frame, idx 0 shows 7 (`seg`=0000111).
3. hour=8'h05 with LZB=1.
   - idx 5: `an`=011111, `seg`=0000000.
   - idx 4 shows 5 with `dp`=1.
4. `blink_sel`=10, min=8'h34, 8 frames.
   - idx 2 and idx 3 are visible for 2 frames, then blank (`seg`=0, `dp`=0) for 2 frames, alternating.
   - sec and hour digits are never blanked.
5. sec=8'hA3.
   - idx 1 shows dash, `seg`=1000000.
   - idx 0 shows 3, `seg`=1001111.
6. Assert `rst_n`=0 for one edge mid-digit at idx 3.
   - Next edge: `an`=111111.
   - After release, the sequence restarts at idx 0 exactly as in scenario 1.
